// File: rtl/interleave_pkg.sv
// Shared types for the interleaved add/multiply/accumulate pipeline.
// The typedefs are sized from the default configuration below.
package interleave_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int LANES_DEF = 2;
  localparam int ACC_W_DEF = 2 * WIDTH_DEF + 4;
  localparam int IDX_W     = (LANES_DEF > 1) ? $clog2(LANES_DEF) : 1;

  typedef logic [IDX_W-1:0] lane_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lane_state_e;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] sum;
    logic [WIDTH_DEF-1:0] diff;
    logic                 acc_en;
    logic                 acc_clr;
  } s1_payload_t;

  // Round-robin successor; lane count need not be a power of two.
  function automatic lane_idx_t next_idx(lane_idx_t idx, int unsigned lanes);
    return (32'(idx) == lanes - 1) ? lane_idx_t'(0) : lane_idx_t'(idx + 1'b1);
  endfunction

endpackage

// File: rtl/arith_lane.sv
// One multicycle multiplier lane: captures sum/diff at dispatch, holds the product until retired.
//   state | meaning
//   IDLE  | free, waiting for dispatch
//   BUSY  | operands held stable while the product settles (LANES-1 cycles)
//   DONE  | product valid, waiting for in-order retirement
module arith_lane
  import interleave_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start,
  input  logic               retire,
  input  s1_payload_t        payload,
  output logic               idle,
  output logic               done,
  output logic [2*WIDTH-1:0] prod,
  output logic               acc_en,
  output logic               acc_clr
);

  localparam int CNT_W = $clog2(LANES);
  // The DONE cycle counts towards occupancy, so a lane re-dispatches every LANES cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LANES - 2);

  lane_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a, op_b;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = DONE;
      DONE: begin
        if (start)       state_nxt = BUSY;
        else if (retire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      acc_en  <= 1'b0;
      acc_clr <= 1'b0;
      prod    <= '0;
    end else begin
      if (start) begin
        cnt     <= CNT_LOAD;
        op_a    <= payload.sum;
        op_b    <= payload.diff;
        acc_en  <= payload.acc_en;
        acc_clr <= payload.acc_clr;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == BUSY && cnt == '0)
        prod <= {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
    end
  end

  assign idle = (state == IDLE);
  assign done = (state == DONE);

endmodule

// File: rtl/interleaved_arith_pipe.sv
// Interleaved add/multiply/accumulate pipeline: S1 sum/diff register, round-robin
// multiplier lanes, in-order retirement into an output register with accumulator.
module interleaved_arith_pipe
  import interleave_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LANES = LANES_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   operand_1,
  input  logic [WIDTH-1:0]   operand_2,
  input  logic               acc_en_i,
  input  logic               acc_clr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ACC_W-1:0]   result,
  output logic [2*WIDTH-1:0] result_2
);

  s1_payload_t        s1_q;
  logic               s1_valid;
  lane_idx_t          disp_ptr, ret_ptr;
  logic               accept, dispatch, retire_fire;
  logic [WIDTH-1:0]   in_sum, in_diff;

  logic [LANES-1:0]   lane_idle, lane_done, lane_start, lane_retire, lane_en, lane_clr;
  logic [2*WIDTH-1:0] lane_prod [LANES];

  logic [2*WIDTH-1:0] ret_prod;
  logic [ACC_W-1:0]   ret_prod_ext, acc_q, acc_sum;

  assign in_sum  = operand_1 + operand_2;
  assign in_diff = operand_1 - operand_2;

  // A lane retiring this cycle is free for dispatch at the same edge; this keeps 1 txn/cycle.
  assign retire_fire = lane_done[ret_ptr] && (!out_valid_o || out_ready_i);
  assign dispatch    = s1_valid && (lane_idle[disp_ptr] || lane_retire[disp_ptr]);
  assign in_ready_o  = rst_ni && (!s1_valid || dispatch);
  assign accept      = in_valid_i && in_ready_o;

  always_comb begin
    lane_start  = '0;
    lane_retire = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_start[i]  = dispatch && (disp_ptr == lane_idx_t'(i));
      lane_retire[i] = retire_fire && (ret_ptr == lane_idx_t'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q     <= '0;
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_q     <= '{sum: in_sum, diff: in_diff, acc_en: acc_en_i, acc_clr: acc_clr_i};
      s1_valid <= 1'b1;
    end else if (dispatch) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      disp_ptr <= '0;
      ret_ptr  <= '0;
    end else begin
      if (dispatch)    disp_ptr <= next_idx(disp_ptr, LANES);
      if (retire_fire) ret_ptr  <= next_idx(ret_ptr, LANES);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    arith_lane #(
      .WIDTH (WIDTH),
      .LANES (LANES)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start   (lane_start[g]),
      .retire  (lane_retire[g]),
      .payload (s1_q),
      .idle    (lane_idle[g]),
      .done    (lane_done[g]),
      .prod    (lane_prod[g]),
      .acc_en  (lane_en[g]),
      .acc_clr (lane_clr[g])
    );
  end

  assign ret_prod     = lane_prod[ret_ptr];
  assign ret_prod_ext = ACC_W'(ret_prod);
  assign acc_sum      = acc_q + ret_prod_ext;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      result      <= '0;
      result_2    <= '0;
      acc_q       <= '0;
    end else if (retire_fire) begin
      out_valid_o <= 1'b1;
      result_2    <= ret_prod;
      if (lane_clr[ret_ptr]) begin
        acc_q  <= ret_prod_ext;
        result <= ret_prod_ext;
      end else if (lane_en[ret_ptr]) begin
        acc_q  <= acc_sum;
        result <= acc_sum;
      end else begin
        result <= ret_prod_ext;
      end
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_interleaved_arith_pipe.sv
// Scoreboard bench for interleaved_arith_pipe (WIDTH=8, LANES=2): expectations are queued at
// input acceptance and popped when an output beat is accepted.
module tb_interleaved_arith_pipe;

  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int ACC_W = 2 * WIDTH + 4;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               in_valid_i = 1'b0;
  logic               in_ready_o;
  logic [WIDTH-1:0]   operand_1 = '0;
  logic [WIDTH-1:0]   operand_2 = '0;
  logic               acc_en_i = 1'b0;
  logic               acc_clr_i = 1'b0;
  logic               out_valid_o;
  logic               out_ready_i = 1'b1;
  logic [ACC_W-1:0]   result;
  logic [2*WIDTH-1:0] result_2;

  always #5 clk_i = ~clk_i;

  interleaved_arith_pipe #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .ACC_W (ACC_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .operand_1   (operand_1),
    .operand_2   (operand_2),
    .acc_en_i    (acc_en_i),
    .acc_clr_i   (acc_clr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result      (result),
    .result_2    (result_2)
  );

  typedef struct {
    logic [ACC_W-1:0]   res;
    logic [2*WIDTH-1:0] prod;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [ACC_W-1:0] model_acc = '0;
  int               n_checks = 0;
  int               n_fail = 0;
  int               beats = 0;
  int               cyc = 0;
  int               last_beat_cyc = 0;
  int               prev_beat_cyc = 0;
  bit               saw_stall = 0;
  bit               rnd_done = 0;
  bit               hold_q = 0;
  logic [ACC_W-1:0]   hold_res;
  logic [2*WIDTH-1:0] hold_prod;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic en, input logic clr);
    logic [WIDTH-1:0]   s, d;
    logic [2*WIDTH-1:0] p;
    exp_t               e;
    s = a + b;
    d = a - b;
    p = (2*WIDTH)'(s) * (2*WIDTH)'(d);
    if (clr) begin
      model_acc = ACC_W'(p);
      e.res     = model_acc;
    end else if (en) begin
      model_acc = model_acc + ACC_W'(p);
      e.res     = model_acc;
    end else begin
      e.res = ACC_W'(p);
    end
    e.prod = p;
    exp_q.push_back(e);
  endtask

  // Called just after a posedge; returns just after the posedge that accepted the txn.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic en, input logic clr, output int waited);
    bit sent = 0;
    waited     = 0;
    in_valid_i = 1'b1;
    operand_1  = a;
    operand_2  = b;
    acc_en_i   = en;
    acc_clr_i  = clr;
    while (!sent) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        model_push(a, b, en, clr);
        sent = 1;
      end
      @(posedge clk_i);
      #1;
      if (!sent) begin
        waited++;
        if (waited > 200) begin
          chk("send_timeout", 32'(waited), 0);
          sent = 1;
        end
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk_i);
      n++;
    end
    chk(tag, 32'(exp_q.size()), 0);
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      hold_q = 0;
    end else begin
      if (hold_q) begin
        chk("hold_valid", 32'(out_valid_o), 1);
        chk("hold_result", 32'(result), 32'(hold_res));
        chk("hold_result_2", 32'(result_2), 32'(hold_prod));
      end
      hold_q    = out_valid_o && !out_ready_i;
      hold_res  = result;
      hold_prod = result_2;
      if (in_valid_i && !in_ready_o) saw_stall = 1;
      if (out_valid_o && out_ready_i) begin
        beats++;
        prev_beat_cyc = last_beat_cyc;
        last_beat_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(result), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", 32'(result), 32'(mon_e.res));
          chk("result_2", 32'(result_2), 32'(mon_e.prod));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int lat;
    int b0;
    logic [WIDTH-1:0] ra, rb;

    // reset state
    @(negedge clk_i);
    chk("rst_out_valid", 32'(out_valid_o), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_result_2", 32'(result_2), 0);
    chk("rst_in_ready", 32'(in_ready_o), 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_in_ready", 32'(in_ready_o), 1);
    chk("post_rst_out_valid", 32'(out_valid_o), 0);
    @(posedge clk_i);
    #1;

    // single txn and latency
    send(8'd5, 8'd3, 1'b0, 1'b0, w);
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!out_valid_o && lat < 20);
    chk("latency", 32'(lat), 32'(LANES + 2));
    drain("drain_single");

    // diff wraps
    send(8'd3, 8'd5, 1'b0, 1'b0, w);
    drain("drain_wrap");

    // back-to-back with accumulate
    b0 = beats;
    send(8'd5, 8'd3, 1'b0, 1'b1, w);
    chk("b2b_stall_0", 32'(w), 0);
    send(8'd4, 8'd2, 1'b1, 1'b0, w);
    chk("b2b_stall_1", 32'(w), 0);
    send(8'd2, 8'd2, 1'b1, 1'b0, w);
    chk("b2b_stall_2", 32'(w), 0);
    drain("drain_b2b");
    chk("b2b_beats", 32'(beats - b0), 3);
    chk("b2b_spacing", 32'(last_beat_cyc - prev_beat_cyc), 1);

    // output backpressure for 10 cycles with 6 txns offered
    b0 = beats;
    saw_stall = 0;
    out_ready_i = 1'b0;
    fork
      begin
        repeat (10) @(posedge clk_i);
        #1 out_ready_i = 1'b1;
      end
      begin
        for (int i = 0; i < 6; i++)
          send(8'(10 + i), 8'(i), 1'(i % 2), 1'(i == 0), w);
      end
    join
    drain("drain_stall");
    chk("stall_in_ready_drop", 32'(saw_stall), 1);
    chk("stall_beats", 32'(beats - b0), 6);

    // reset with txns in flight
    send(8'd9, 8'd1, 1'b0, 1'b1, w);
    send(8'd7, 8'd2, 1'b1, 1'b0, w);
    send(8'd6, 8'd3, 1'b1, 1'b0, w);
    rst_ni = 1'b0;
    exp_q.delete();
    model_acc = '0;
    @(negedge clk_i);
    chk("midrst_out_valid", 32'(out_valid_o), 0);
    chk("midrst_in_ready", 32'(in_ready_o), 0);
    chk("midrst_result", 32'(result), 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    b0 = beats;
    repeat (10) @(posedge clk_i);
    #1;
    chk("midrst_no_output", 32'(beats - b0), 0);
    send(8'd5, 8'd3, 1'b1, 1'b0, w);
    send(8'd4, 8'd2, 1'b0, 1'b1, w);
    send(8'd2, 8'd1, 1'b1, 1'b0, w);
    drain("drain_after_rst");

    // random traffic with random output backpressure
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk_i);
          #1 out_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join_none
    b0 = beats;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1;
      end
    end
    rnd_done = 1;
    @(posedge clk_i);
    #2 out_ready_i = 1'b1;
    drain("drain_random");
    chk("random_beats", 32'(beats - b0), 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
